// File: rtl/frame_mem_arbiter.sv
// ---------------------------------------------------------------------------
// frame_mem_arbiter
//
// Shares the single frame-memory command port between the camera write path
// (high priority) and the display line-fetch path (low priority). Write
// bursts are capped at WR_BURST_MAX words per grant. Outstanding reads are
// drained before the port is handed to the writer. write_flag tells the line
// fetcher to stop issuing while the writer owns, or is about to own, the port.
//
// Optional feature (macro FRAME_ARB_STARVE_GUARD_EN):
//   When defined, a starve counter limits how long a pending line fetch can
//   be held off by a write burst. After RD_STARVE_LIMIT cycles of a write
//   burst with rd_req high, the burst is cut and the reader gets one forced
//   grant. When undefined, writes have strict priority and no counter exists.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_req/valid/addr/data, wr_ready        camera write port
//   rd_req/valid/addr, rd_ready             line-fetch command port
//   rd_data, rd_data_valid                  registered read return
//   write_flag                              registered writer-owns-port flag
//   mem_cmd_valid/we/addr, mem_wdata, mem_cmd_ready   memory command port
//   mem_rdata, mem_rdata_valid              memory read return
// ---------------------------------------------------------------------------
module frame_mem_arbiter #(
    parameter int ADDR_W          = 24,
    parameter int DATA_W          = 16,
    parameter int WR_BURST_MAX    = 800,
    parameter int RD_OUTSTANDING  = 4,
    parameter int RD_STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              write_flag,
    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_cmd_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid
);

    localparam int OUT_W  = $clog2(RD_OUTSTANDING + 1);
    localparam int WCNT_W = $clog2(WR_BURST_MAX + 1);
    localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(RD_OUTSTANDING);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WR_BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [WCNT_W-1:0]   wr_cnt_r;
    logic [WCNT_W-1:0]   wr_cnt_next_s;
    logic [OUT_W-1:0]    outst_r;
    logic                rd_room_s;
    logic                rd_acc_s;
    logic                wr_acc_s;
    logic                rd_ret_s;
    logic                starve_cut_s;
    logic                force_rd_s;

    logic                cmd_valid_s;
    logic                cmd_we_s;
    logic [ADDR_W-1:0]   cmd_addr_s;
    logic [DATA_W-1:0]   cmd_wdata_s;
    logic                wr_ready_s;
    logic                rd_ready_s;

    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_data_valid_r;
    logic                write_flag_r;

    assign rd_room_s = (outst_r < OUT_MAX);
    // A return with nothing outstanding is stale (e.g. issued before reset).
    assign rd_ret_s  = mem_rdata_valid & (outst_r != {OUT_W{1'b0}});

`ifdef FRAME_ARB_STARVE_GUARD_EN
    localparam int STV_W = $clog2(RD_STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(RD_STARVE_LIMIT);

    logic [STV_W-1:0] starve_cnt_r;
    logic [STV_W-1:0] starve_next_s;
    logic             force_rd_r;

    // Starve counter advance: cycles spent in WR while the reader waits.
    always_comb begin
        starve_next_s = starve_cnt_r;
        if ((state_r == ST_WR) && rd_req && (starve_cnt_r != STV_MAX)) begin
            starve_next_s = starve_cnt_r + {{(STV_W-1){1'b0}}, 1'b1};
        end else begin
            starve_next_s = starve_cnt_r;
        end
    end

    // The burst ends after the cycle in which the limit is reached.
    assign starve_cut_s = (state_r == ST_WR) && rd_req && (starve_next_s == STV_MAX);
    assign force_rd_s   = force_rd_r;

    // Starve counter register, cleared whenever the reader is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {STV_W{1'b0}};
        end else if ((state_r != ST_RD) && (state_next_s == ST_RD)) begin
            starve_cnt_r <= {STV_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_next_s;
        end
    end

    // Forced-read token: set by a starve cut, held through the RD grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            force_rd_r <= 1'b0;
        end else if (starve_cut_s) begin
            force_rd_r <= 1'b1;
        end else if ((state_r == ST_RD) && (state_next_s != ST_RD)) begin
            force_rd_r <= 1'b0;
        end else begin
            force_rd_r <= force_rd_r;
        end
    end
`else
    assign starve_cut_s = 1'b0;
    assign force_rd_s   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and command steering from the owning port.
    always_comb begin
        state_next_s  = state_r;
        wr_cnt_next_s = wr_cnt_r;
        cmd_valid_s   = 1'b0;
        cmd_we_s      = 1'b0;
        cmd_addr_s    = {ADDR_W{1'b0}};
        cmd_wdata_s   = {DATA_W{1'b0}};
        wr_ready_s    = 1'b0;
        rd_ready_s    = 1'b0;
        wr_acc_s      = 1'b0;
        rd_acc_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (force_rd_s && rd_req) begin
                    state_next_s = ST_RD;
                end else if (wr_req) begin
                    state_next_s = ST_WR;
                end else if (rd_req) begin
                    state_next_s = ST_RD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR: begin
                cmd_valid_s = wr_valid;
                cmd_we_s    = 1'b1;
                cmd_addr_s  = wr_addr;
                cmd_wdata_s = wr_data;
                wr_ready_s  = mem_cmd_ready;
                wr_acc_s    = wr_valid & mem_cmd_ready;
                if (wr_acc_s) begin
                    wr_cnt_next_s = wr_cnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
                end else begin
                    wr_cnt_next_s = wr_cnt_r;
                end
                // Exit is judged on the count including this cycle's word.
                if (!wr_req || (wr_cnt_next_s == WCNT_MAX) || starve_cut_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WR;
                end
            end
            ST_RD: begin
                cmd_valid_s = rd_valid & rd_room_s;
                cmd_we_s    = 1'b0;
                cmd_addr_s  = rd_addr;
                rd_ready_s  = mem_cmd_ready & rd_room_s;
                rd_acc_s    = rd_valid & mem_cmd_ready & rd_room_s;
                // A forced grant ignores the writer until the line is done.
                if ((wr_req && !force_rd_s) || !rd_req) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RD;
                end
            end
            ST_DRAIN: begin
                if (outst_r == {OUT_W{1'b0}}) begin
                    if (wr_req) begin
                        state_next_s = ST_WR;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Write burst counter; held at zero outside WR so every grant starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r <= {WCNT_W{1'b0}};
        end else if (state_r != ST_WR) begin
            wr_cnt_r <= {WCNT_W{1'b0}};
        end else begin
            wr_cnt_r <= wr_cnt_next_s;
        end
    end

    // Outstanding-read counter: accepted reads minus returned reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_r <= {OUT_W{1'b0}};
        end else begin
            case ({rd_acc_s, rd_ret_s})
                2'b10:   outst_r <= outst_r + {{(OUT_W-1){1'b0}}, 1'b1};
                2'b01:   outst_r <= outst_r - {{(OUT_W-1){1'b0}}, 1'b1};
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Read return path, one register stage; forwarded in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r       <= {DATA_W{1'b0}};
            rd_data_valid_r <= 1'b0;
        end else if (rd_ret_s) begin
            rd_data_r       <= mem_rdata;
            rd_data_valid_r <= 1'b1;
        end else begin
            rd_data_r       <= rd_data_r;
            rd_data_valid_r <= 1'b0;
        end
    end

    // write_flag follows the next state so it rises with the grant decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_flag_r <= 1'b0;
        end else begin
            write_flag_r <= (state_next_s == ST_WR) ||
                            ((state_next_s == ST_DRAIN) && wr_req);
        end
    end

    // Command outputs are combinational; they are forced quiet during reset.
    assign mem_cmd_valid = cmd_valid_s & ~rst;
    assign mem_cmd_we    = cmd_we_s & ~rst;
    assign mem_cmd_addr  = rst ? {ADDR_W{1'b0}} : cmd_addr_s;
    assign mem_wdata     = rst ? {DATA_W{1'b0}} : cmd_wdata_s;
    assign wr_ready      = wr_ready_s & ~rst;
    assign rd_ready      = rd_ready_s & ~rst;
    assign rd_data       = rd_data_r;
    assign rd_data_valid = rd_data_valid_r;
    assign write_flag    = write_flag_r;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Testbench for frame_mem_arbiter (default build, strict write priority).
// A directed vector table covers single-cycle behaviour; hand-written
// sequences cover draining, burst limits, turnaround and reset mid-operation.
module tb_frame_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, wr_valid, wr_ready;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req, rd_valid, rd_ready;
    logic [23:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_data_valid, write_flag;
    logic        mem_cmd_valid, mem_cmd_we, mem_cmd_ready;
    logic [23:0] mem_cmd_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_rdata_valid;

    always #5 clk = ~clk;

    frame_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .write_flag(write_flag),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
        .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    typedef struct {
        logic        wreq, wv, rreq, rv, mrdy, mrv;
        logic [23:0] wa, ra;
        logic [15:0] md;
        logic        e_wrdy, e_rrdy, e_cv, e_we, e_wf, e_rdv;
        logic [23:0] e_addr;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t tbl[26];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_req = 1'b0; wr_valid = 1'b0; wr_addr = 24'h0; wr_data = 16'h0;
        rd_req = 1'b0; rd_valid = 1'b0; rd_addr = 24'h0;
        mem_cmd_ready = 1'b0; mem_rdata = 16'h0; mem_rdata_valid = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic wreq, input logic wv, input logic [23:0] wa,
        input logic rreq, input logic rv, input logic [23:0] ra,
        input logic mrdy, input logic mrv, input logic [15:0] md,
        input logic e_wrdy, input logic e_rrdy, input logic e_cv, input logic e_we,
        input logic [23:0] e_addr, input logic e_wf, input logic e_rdv,
        input logic [15:0] e_rdata);
        vec_t v;
        v.wreq = wreq; v.wv = wv; v.wa = wa; v.rreq = rreq; v.rv = rv; v.ra = ra;
        v.mrdy = mrdy; v.mrv = mrv; v.md = md;
        v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_cv = e_cv; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wf = e_wf; v.e_rdv = e_rdv; v.e_rdata = e_rdata;
        return v;
    endfunction

    initial begin
        // ---------------- vector table ----------------
        // five-word write burst at 0x000100
        tbl[0]  = mk(1'b1,1'b1,24'h100, 1'b0,1'b0,24'h0, 1'b1,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0);
        tbl[1]  = mk(1'b1,1'b1,24'h100, 1'b0,1'b0,24'h0, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b1,1'b1,24'h100, 1'b1,1'b0,16'h0);
        tbl[2]  = mk(1'b1,1'b1,24'h101, 1'b0,1'b0,24'h0, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b1,1'b1,24'h101, 1'b1,1'b0,16'h0);
        tbl[3]  = mk(1'b1,1'b1,24'h102, 1'b0,1'b0,24'h0, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b1,1'b1,24'h102, 1'b1,1'b0,16'h0);
        tbl[4]  = mk(1'b1,1'b1,24'h103, 1'b0,1'b0,24'h0, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b1,1'b1,24'h103, 1'b1,1'b0,16'h0);
        tbl[5]  = mk(1'b1,1'b1,24'h104, 1'b0,1'b0,24'h0, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b1,1'b1,24'h104, 1'b1,1'b0,16'h0);
        tbl[6]  = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b0,1'b1,24'h0,   1'b1,1'b0,16'h0);
        tbl[7]  = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0, 1'b0,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0);
        // simultaneous requests: write first, then one read
        tbl[8]  = mk(1'b1,1'b1,24'h200, 1'b1,1'b1,24'h500, 1'b1,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0);
        tbl[9]  = mk(1'b1,1'b1,24'h200, 1'b1,1'b1,24'h500, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b1,1'b1,24'h200, 1'b1,1'b0,16'h0);
        tbl[10] = mk(1'b0,1'b0,24'h0,   1'b1,1'b1,24'h500, 1'b1,1'b0,16'h0, 1'b1,1'b0,1'b0,1'b1,24'h0,   1'b1,1'b0,16'h0);
        tbl[11] = mk(1'b0,1'b0,24'h0,   1'b1,1'b1,24'h500, 1'b1,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0);
        tbl[12] = mk(1'b0,1'b0,24'h0,   1'b1,1'b1,24'h500, 1'b1,1'b0,16'h0, 1'b0,1'b1,1'b1,1'b0,24'h500, 1'b0,1'b0,16'h0);
        tbl[13] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b1,1'b0,16'h0, 1'b0,1'b1,1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0);
        tbl[14] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b1,1'b1,16'hABCD, 1'b0,1'b0,1'b0,1'b0,24'h0, 1'b0,1'b0,16'h0);
        tbl[15] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b1,16'hABCD);
        tbl[16] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b0,16'hABCD);
        // read with memory back-pressure, then a stale return
        tbl[17] = mk(1'b0,1'b0,24'h0,   1'b1,1'b1,24'h600, 1'b0,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b0,16'hABCD);
        tbl[18] = mk(1'b0,1'b0,24'h0,   1'b1,1'b1,24'h600, 1'b0,1'b0,16'h0, 1'b0,1'b0,1'b1,1'b0,24'h600, 1'b0,1'b0,16'hABCD);
        tbl[19] = mk(1'b0,1'b0,24'h0,   1'b1,1'b1,24'h600, 1'b0,1'b0,16'h0, 1'b0,1'b0,1'b1,1'b0,24'h600, 1'b0,1'b0,16'hABCD);
        tbl[20] = mk(1'b0,1'b0,24'h0,   1'b1,1'b1,24'h600, 1'b1,1'b0,16'h0, 1'b0,1'b1,1'b1,1'b0,24'h600, 1'b0,1'b0,16'hABCD);
        tbl[21] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b1,1'b0,16'h0, 1'b0,1'b1,1'b0,1'b0,24'h0,   1'b0,1'b0,16'hABCD);
        tbl[22] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b1,1'b1,16'h1234, 1'b0,1'b0,1'b0,1'b0,24'h0, 1'b0,1'b0,16'hABCD);
        tbl[23] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b1,16'h1234);
        tbl[24] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b0,1'b1,16'h5555, 1'b0,1'b0,1'b0,1'b0,24'h0, 1'b0,1'b0,16'h1234);
        tbl[25] = mk(1'b0,1'b0,24'h0,   1'b0,1'b0,24'h0,   1'b0,1'b0,16'h0, 1'b0,1'b0,1'b0,1'b0,24'h0,   1'b0,1'b0,16'h1234);

        // ---------------- reset with requests asserted ----------------
        idle_inputs();
        rst = 1'b1;
        wr_req = 1'b1; wr_valid = 1'b1; mem_cmd_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset ctrl", {26'd0, wr_ready, rd_ready, mem_cmd_valid, mem_cmd_we, write_flag, rd_data_valid}, 32'd0);
        check("reset data", {mem_cmd_addr, 8'd0} | {16'd0, mem_wdata} | {16'd0, rd_data}, 32'd0);
        tick();
        rst = 1'b0;
        idle_inputs();

        // ---------------- table ----------------
        for (int i = 0; i < 26; i++) begin
            wr_req = tbl[i].wreq; wr_valid = tbl[i].wv; wr_addr = tbl[i].wa;
            wr_data = tbl[i].wa[15:0] ^ 16'hC0DE;
            rd_req = tbl[i].rreq; rd_valid = tbl[i].rv; rd_addr = tbl[i].ra;
            mem_cmd_ready = tbl[i].mrdy; mem_rdata_valid = tbl[i].mrv; mem_rdata = tbl[i].md;
            @(negedge clk);
            check($sformatf("row%0d ctrl", i),
                  {26'd0, wr_ready, rd_ready, mem_cmd_valid, mem_cmd_we, write_flag, rd_data_valid},
                  {26'd0, tbl[i].e_wrdy, tbl[i].e_rrdy, tbl[i].e_cv, tbl[i].e_we, tbl[i].e_wf, tbl[i].e_rdv});
            check($sformatf("row%0d addr", i), {8'd0, mem_cmd_addr}, {8'd0, tbl[i].e_addr});
            check($sformatf("row%0d wdata", i), {16'd0, mem_wdata},
                  {16'd0, tbl[i].e_we ? (tbl[i].wa[15:0] ^ 16'hC0DE) : 16'h0000});
            check($sformatf("row%0d rdata", i), {16'd0, rd_data}, {16'd0, tbl[i].e_rdata});
            tick();
        end
        idle_inputs();

        // ---------------- drain: six reads, latency 3, then a write ----------------
        begin
            int          issued, returned, viol;
            logic        got_write, nv;
            logic [2:0]  lv;
            logic [15:0] ld [3];
            logic [15:0] nd;
            logic [15:0] exp_q [$];
            issued = 0; returned = 0; viol = 0; got_write = 1'b0; lv = 3'b000;
            ld[0] = 16'h0; ld[1] = 16'h0; ld[2] = 16'h0;
            rd_req = 1'b1; mem_cmd_ready = 1'b1;
            for (int cyc = 0; cyc < 80 && !got_write; cyc++) begin
                mem_rdata_valid = lv[2]; mem_rdata = ld[2];
                rd_valid = (issued < 6);
                rd_addr  = 24'h000400 + 24'(issued);
                wr_req   = (issued >= 6); wr_valid = (issued >= 6);
                wr_addr  = 24'h000300; wr_data = 16'h7777;
                @(negedge clk);
                if (write_flag && rd_ready) viol++;
                if (rd_data_valid) begin
                    if (exp_q.size() > 0) check("drain rd_data", {16'd0, rd_data}, {16'd0, exp_q.pop_front()});
                    else check("drain extra return", 32'd1, 32'd0);
                    returned++;
                end
                nv = mem_cmd_valid && mem_cmd_ready && !mem_cmd_we;
                nd = rd_addr[15:0] ^ 16'h5A5A;
                if (nv) begin
                    check("drain rd addr", {8'd0, mem_cmd_addr}, {8'd0, rd_addr});
                    issued++;
                    exp_q.push_back(nd);
                end
                if (wr_ready && wr_valid) begin
                    got_write = 1'b1;
                    check("drain returns before write", 32'(returned), 32'd6);
                    check("drain write_flag", {31'd0, write_flag}, 32'd1);
                end
                lv = {lv[1:0], nv};
                ld[2] = ld[1]; ld[1] = ld[0]; ld[0] = nd;
                tick();
            end
            check("drain write seen", {31'd0, got_write}, 32'd1);
            check("drain issued", 32'(issued), 32'd6);
            check("drain flag vs rd_ready", 32'(viol), 32'd0);
            idle_inputs();
            repeat (3) tick();
        end

        // ---------------- RD->WR turnaround with nothing outstanding ----------------
        mem_cmd_ready = 1'b1; rd_req = 1'b1;
        tick();
        wr_req = 1'b1; wr_valid = 1'b1; wr_addr = 24'h000350;
        @(negedge clk);
        check("turn c0 wr_ready", {30'd0, wr_ready, write_flag}, 32'd0);
        tick();
        @(negedge clk);
        check("turn c1 wr_ready/flag", {30'd0, wr_ready, write_flag}, 32'd1);
        tick();
        @(negedge clk);
        check("turn c2 accept", {29'd0, wr_ready, mem_cmd_valid, mem_cmd_we}, 32'd7);
        tick();
        idle_inputs();
        repeat (3) tick();

        // ---------------- 900-word burst with reader waiting ----------------
        begin
            int remaining, cur, nrun, rd_seen;
            int runs [4];
            logic got_rd;
            remaining = 900; cur = 0; nrun = 0; rd_seen = 0; got_rd = 1'b0;
            for (int k = 0; k < 4; k++) runs[k] = 0;
            rd_req = 1'b1; mem_cmd_ready = 1'b1;
            for (int cyc = 0; cyc < 2000 && remaining > 0; cyc++) begin
                wr_req = 1'b1; wr_valid = 1'b1;
                wr_addr = 24'h010000 + 24'(900 - remaining);
                @(negedge clk);
                if (rd_ready) rd_seen++;
                if (wr_ready) begin
                    remaining--; cur++;
                end else if (cur > 0) begin
                    if (nrun < 4) runs[nrun] = cur;
                    nrun++; cur = 0;
                end
                tick();
            end
            if (cur > 0) begin
                if (nrun < 4) runs[nrun] = cur;
                nrun++;
            end
            wr_req = 1'b0; wr_valid = 1'b0;
            check("burst all words", 32'(remaining), 32'd0);
            check("burst grant count", 32'(nrun), 32'd2);
            check("burst first grant", 32'(runs[0]), 32'd800);
            check("burst second grant", 32'(runs[1]), 32'd100);
            check("burst rd_ready during writes", 32'(rd_seen), 32'd0);
            for (int cyc = 0; cyc < 10 && !got_rd; cyc++) begin
                @(negedge clk);
                if (rd_ready) got_rd = 1'b1;
                tick();
            end
            check("burst read granted after", {31'd0, got_rd}, 32'd1);
            idle_inputs();
            repeat (3) tick();
        end

        // ---------------- reset in the middle of a read ----------------
        rd_req = 1'b1; rd_valid = 1'b1; rd_addr = 24'h000700; mem_cmd_ready = 1'b1;
        tick();
        @(negedge clk);
        check("midrst read active", {31'd0, mem_cmd_valid}, 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst outputs gated", {29'd0, mem_cmd_valid, rd_ready, wr_ready}, 32'd0);
        tick();
        rst = 1'b0; rd_req = 1'b0; rd_valid = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        check("midrst stale return dropped", {30'd0, rd_data_valid, write_flag}, 32'd0);
        check("midrst rd_data cleared", {16'd0, rd_data}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
